// File: rtl/ks_mem_responder.sv
// ks_mem_responder: 32 x 16-bit RAM for the K&S processor with a host boot-loader front-end.
// Optional KS_MEM_WPROT_EN: write-protects the loaded program image while the processor runs.
module ks_mem_responder #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ram_addr,
  input  logic              ram_wr_en,
  input  logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_rdata,
  input  logic              load_start,
  input  logic [5:0]        load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
`ifdef KS_MEM_WPROT_EN
  ,
  output logic              wprot_violation
`endif
);

  typedef enum logic [1:0] {S_WAIT, S_LOAD, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [4:0]        ptr;
  logic [5:0]        len;
  logic              len_ok, start_ok, start_bad;
  logic              accept, last_word, wr_blocked, run_wr, mem_we;
  logic [4:0]        mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign len_ok = (load_len != 6'd0) && (load_len <= 6'(DEPTH));

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    accept     = 1'b0;
    last_word  = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    wr_blocked = 1'b0;
    // A new load request is honoured from WAIT or RUN only; LOAD ignores it.
    if (state != S_LOAD) begin
      start_ok  = load_start && len_ok;
      start_bad = load_start && !len_ok;
    end
    case (state)
      S_WAIT: if (start_ok) state_nxt = S_LOAD;
      S_LOAD: begin
        load_ready = 1'b1;
        accept     = load_valid;
        last_word  = load_valid && ({1'b0, ptr} == len - 6'd1);
        if (last_word) state_nxt = S_RUN;
      end
      S_RUN:  if (start_ok) state_nxt = S_LOAD;
      default: state_nxt = S_WAIT;
    endcase
`ifdef KS_MEM_WPROT_EN
    wr_blocked = ({1'b0, ram_addr} < len);
`endif
    run_wr    = (state == S_RUN) && ram_wr_en && !wr_blocked;
    mem_we    = accept || run_wr;
    mem_waddr = accept ? ptr : ram_addr;
    mem_wdata = accept ? load_data : ram_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      ptr       <= '0;
      len       <= '0;
      ram_rdata <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= last_word;
      cpu_rst_n <= (state_nxt == S_RUN);
      if (start_bad) load_err <= 1'b1;
      if (start_ok) begin
        len <= load_len;
        ptr <= '0;
      end else if (accept) begin
        ptr <= ptr + 5'd1;
      end
      // Read-before-write: the array update below lands after this sample.
      ram_rdata <= (state == S_RUN && state_nxt == S_RUN) ? mem[ram_addr] : '0;
    end
  end

  // Program image survives rst_n, so the array has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef KS_MEM_WPROT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wprot_violation <= 1'b0;
    end else if (start_ok) begin
      wprot_violation <= 1'b0;
    end else if (state == S_RUN && ram_wr_en && wr_blocked) begin
      wprot_violation <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ks_mem_responder.sv
// Self-checking bench for ks_mem_responder: directed load scenarios plus randomized RUN traffic
// checked against an array model of the RAM (honours KS_MEM_WPROT_EN when defined).
module tb_ks_mem_responder;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic [4:0]  ram_addr   = '0;
  logic        ram_wr_en  = 1'b0;
  logic [15:0] ram_wdata  = '0;
  logic [15:0] ram_rdata;
  logic        load_start = 1'b0;
  logic [5:0]  load_len   = '0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data  = '0;
  logic        load_ready, cpu_rst_n, load_done, load_err;
`ifdef KS_MEM_WPROT_EN
  logic        wprot_violation;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] model_mem [32];
  int  model_len  = 0;
  bit  model_viol = 1'b0;

  ks_mem_responder #(.DEPTH(32), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .load_start(load_start), .load_len(load_len), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err)
`ifdef KS_MEM_WPROT_EN
    , .wprot_violation(wprot_violation)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit prot(input int a);
    bit en;
`ifdef KS_MEM_WPROT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (a < model_len);
  endfunction

  // Streams n words; gappy inserts an idle (load_valid=0, junk data) cycle before each word.
  task automatic load_prog(input int n, input logic [15:0] w [32], input bit gappy,
                           output int cycles, output int ready_cnt, output bit crst_start,
                           output bit done_now, output bit crst_now, output bit rdy_now,
                           output bit timeout);
    int idx;
    bit v, acc;
    ram_wr_en  = 1'b0;
    load_start = 1'b1;
    load_len   = 6'(n);
    @(posedge clk); #1;
    load_start = 1'b0;
    model_viol = 1'b0;
    crst_start = cpu_rst_n;
    idx = 0; cycles = 0; ready_cnt = 0;
    while (idx < n && cycles < 500) begin
      v = gappy ? ((cycles % 2) == 1) : 1'b1;
      load_valid = v;
      load_data  = v ? w[idx] : 16'($urandom);
      if (load_ready) ready_cnt++;
      acc = v && load_ready;
      @(posedge clk); #1;
      if (acc) begin
        model_mem[idx] = w[idx];
        idx++;
      end
      cycles++;
    end
    load_valid = 1'b0;
    timeout   = (idx < n);
    model_len = n;
    done_now  = load_done;
    crst_now  = cpu_rst_n;
    rdy_now   = load_ready;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] d);
    ram_addr  = a;
    ram_wr_en = 1'b0;
    @(posedge clk); #1;
    d = ram_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    ram_addr  = a;
    ram_wr_en = 1'b1;
    ram_wdata = d;
    @(posedge clk); #1;
    ram_wr_en = 1'b0;
    if (prot(int'(a))) model_viol = 1'b1;
    else model_mem[a] = d;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({ram_rdata, load_ready, cpu_rst_n, load_done, load_err} !== 20'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 00000", {ram_rdata, load_ready, cpu_rst_n, load_done, load_err}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if ({load_ready, cpu_rst_n, ram_rdata} !== 18'h0) begin errors++; $display("FAIL wait_outputs: got %h expected 00000", {load_ready, cpu_rst_n, ram_rdata}); end
  endtask

  task automatic test_full_load();
    logic [15:0] w [32];
    logic [15:0] d;
    int cyc, rc;
    bit cs, dn, cn, rn, to;
    foreach (w[i]) w[i] = 16'($urandom);
    load_prog(32, w, 1'b0, cyc, rc, cs, dn, cn, rn, to);
    checks++; if (to || cyc != 32) begin errors++; $display("FAIL full_load_cycles: got %0d (timeout=%0b) expected 32", cyc, to); end
    checks++; if (rc != 32) begin errors++; $display("FAIL full_load_ready: got %0d ready cycles expected 32", rc); end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL full_load_cpu_held: got cpu_rst_n=%0b expected 0", cs); end
    checks++; if ({dn, cn, rn} !== 3'b110) begin errors++; $display("FAIL full_load_end: got done/cpu_rst_n/ready=%b expected 110", {dn, cn, rn}); end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), d);
      checks++; if (d !== model_mem[i]) begin errors++; $display("FAIL full_load_read[%0d]: got %h expected %h", i, d, model_mem[i]); end
    end
  endtask

  task automatic test_load_basic();
    logic [15:0] w [32];
    logic [15:0] d;
    int cyc, rc;
    bit cs, dn, cn, rn, to;
    foreach (w[i]) w[i] = '0;
    w[0] = 16'h8101; w[1] = 16'h8222; w[2] = 16'hFF00;
    load_prog(3, w, 1'b0, cyc, rc, cs, dn, cn, rn, to);
    checks++; if (to || cyc != 3 || rc != 3) begin errors++; $display("FAIL basic_handshake: got cycles=%0d ready=%0d timeout=%0b expected 3/3/0", cyc, rc, to); end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL basic_reload_hold: got cpu_rst_n=%0b expected 0", cs); end
    checks++; if ({dn, cn, rn} !== 3'b110) begin errors++; $display("FAIL basic_end: got done/cpu_rst_n/ready=%b expected 110", {dn, cn, rn}); end
    rd(5'd0, d);
    checks++; if (d !== 16'h8101) begin errors++; $display("FAIL basic_read0: got %h expected 8101", d); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b expected 0", load_done); end
    rd(5'd1, d);
    checks++; if (d !== 16'h8222) begin errors++; $display("FAIL basic_read1: got %h expected 8222", d); end
    rd(5'd2, d);
    checks++; if (d !== 16'hFF00) begin errors++; $display("FAIL basic_read2: got %h expected FF00", d); end
  endtask

  task automatic test_rw_collision();
    logic [15:0] old;
    old = model_mem[20];
    ram_addr = 5'd20; ram_wr_en = 1'b1; ram_wdata = 16'hABCD;
    @(posedge clk); #1;
    ram_wr_en = 1'b0;
    model_mem[20] = 16'hABCD;
    checks++; if (ram_rdata !== old) begin errors++; $display("FAIL collision_old: got %h expected %h", ram_rdata, old); end
    @(posedge clk); #1;
    checks++; if (ram_rdata !== 16'hABCD) begin errors++; $display("FAIL collision_new: got %h expected ABCD", ram_rdata); end
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [15:0] wd, exp;
    bit we;
    for (int i = 0; i < 300; i++) begin
      a  = 5'($urandom);
      we = ($urandom % 3) == 0;
      wd = 16'($urandom);
      ram_addr = a; ram_wr_en = we; ram_wdata = wd;
      exp = model_mem[a];
      if (we) begin
        if (prot(int'(a))) model_viol = 1'b1;
        else model_mem[a] = wd;
      end
      @(posedge clk); #1;
      checks++; if (ram_rdata !== exp) begin errors++; $display("FAIL random_read[%0d] addr %0d: got %h expected %h", i, a, ram_rdata, exp); end
`ifdef KS_MEM_WPROT_EN
      checks++; if (wprot_violation !== model_viol) begin errors++; $display("FAIL random_wprot[%0d]: got %0b expected %0b", i, wprot_violation, model_viol); end
`endif
    end
    ram_wr_en = 1'b0;
  endtask

  task automatic test_load_toggle();
    logic [15:0] w [32];
    logic [15:0] d;
    int cyc, rc;
    bit cs, dn, cn, rn, to;
    foreach (w[i]) w[i] = 16'($urandom);
    load_prog(2, w, 1'b1, cyc, rc, cs, dn, cn, rn, to);
    checks++; if (to || cyc != 4 || rc != 4) begin errors++; $display("FAIL toggle_handshake: got cycles=%0d ready=%0d timeout=%0b expected 4/4/0", cyc, rc, to); end
    checks++; if ({dn, cn, rn} !== 3'b110) begin errors++; $display("FAIL toggle_end: got done/cpu_rst_n/ready=%b expected 110", {dn, cn, rn}); end
    for (int i = 0; i < 3; i++) begin
      rd(5'(i), d);
      checks++; if (d !== model_mem[i]) begin errors++; $display("FAIL toggle_read[%0d]: got %h expected %h", i, d, model_mem[i]); end
    end
  endtask

  task automatic test_reload();
    logic [15:0] w [32];
    logic [15:0] d;
    int cyc, rc;
    bit cs, dn, cn, rn, to;
    foreach (w[i]) w[i] = 16'($urandom);
    load_prog(1, w, 1'b0, cyc, rc, cs, dn, cn, rn, to);
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL reload_hold: got cpu_rst_n=%0b expected 0", cs); end
    checks++; if (to || cyc != 1) begin errors++; $display("FAIL reload_cycles: got %0d (timeout=%0b) expected 1", cyc, to); end
    checks++; if ({dn, cn} !== 2'b11) begin errors++; $display("FAIL reload_release: got done/cpu_rst_n=%b expected 11", {dn, cn}); end
    rd(5'd0, d);
    checks++; if (d !== w[0]) begin errors++; $display("FAIL reload_addr0: got %h expected %h", d, w[0]); end
    rd(5'd1, d);
    checks++; if (d !== model_mem[1]) begin errors++; $display("FAIL reload_addr1_kept: got %h expected %h", d, model_mem[1]); end
  endtask

  task automatic test_wprot();
    logic [15:0] w [32];
    logic [15:0] d;
    int cyc, rc;
    bit cs, dn, cn, rn, to;
    wr(5'd0, 16'h1234);
`ifdef KS_MEM_WPROT_EN
    checks++; if (wprot_violation !== 1'b1) begin errors++; $display("FAIL wprot_set_len1: got %0b expected 1", wprot_violation); end
`endif
    foreach (w[i]) w[i] = 16'($urandom);
    load_prog(4, w, 1'b0, cyc, rc, cs, dn, cn, rn, to);
    checks++; if (to || cyc != 4) begin errors++; $display("FAIL wprot_load: got %0d (timeout=%0b) expected 4", cyc, to); end
`ifdef KS_MEM_WPROT_EN
    checks++; if (wprot_violation !== 1'b0) begin errors++; $display("FAIL wprot_cleared: got %0b expected 0", wprot_violation); end
`endif
    wr(5'd3, 16'h5A5A);
`ifdef KS_MEM_WPROT_EN
    checks++; if (wprot_violation !== 1'b1) begin errors++; $display("FAIL wprot_addr3: got %0b expected 1", wprot_violation); end
`endif
    wr(5'd4, 16'hA5A5);
    rd(5'd3, d);
    checks++; if (d !== model_mem[3]) begin errors++; $display("FAIL wprot_read3: got %h expected %h", d, model_mem[3]); end
    rd(5'd4, d);
    checks++; if (d !== 16'hA5A5) begin errors++; $display("FAIL wprot_read4: got %h expected A5A5", d); end
  endtask

  task automatic test_load_err();
    logic [15:0] d;
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %0b expected 0", load_err); end
    load_start = 1'b1; load_len = 6'd0;
    @(posedge clk); #1;
    load_start = 1'b0;
    checks++; if ({load_err, cpu_rst_n, load_ready} !== 3'b110) begin errors++; $display("FAIL err_len0_run: got err/cpu_rst_n/ready=%b expected 110", {load_err, cpu_rst_n, load_ready}); end
    load_start = 1'b1; load_len = 6'd33;
    @(posedge clk); #1;
    load_start = 1'b0;
    checks++; if ({load_err, cpu_rst_n, load_ready} !== 3'b110) begin errors++; $display("FAIL err_len33_run: got err/cpu_rst_n/ready=%b expected 110", {load_err, cpu_rst_n, load_ready}); end
    rd(5'd4, d);
    checks++; if (d !== model_mem[4]) begin errors++; $display("FAIL err_still_run: got %h expected %h", d, model_mem[4]); end
    repeat (5) @(posedge clk); #1;
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", load_err); end
  endtask

  task automatic test_reset_clear();
    logic [15:0] w [32];
    logic [15:0] d;
    int cyc, rc;
    bit cs, dn, cn, rn, to;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ram_rdata, load_ready, cpu_rst_n, load_done, load_err} !== 20'h0) begin errors++; $display("FAIL async_reset: got %h expected 00000", {ram_rdata, load_ready, cpu_rst_n, load_done, load_err}); end
    model_viol = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ram_addr = 5'd10; ram_wr_en = 1'b1; ram_wdata = ~model_mem[10];
    @(posedge clk); #1;
    ram_wr_en = 1'b0;
    checks++; if ({cpu_rst_n, load_ready, ram_rdata} !== 18'h0) begin errors++; $display("FAIL wait_hold: got %h expected 00000", {cpu_rst_n, load_ready, ram_rdata}); end
    load_start = 1'b1; load_len = 6'd33;
    @(posedge clk); #1;
    load_start = 1'b0;
    checks++; if ({load_err, cpu_rst_n, load_ready} !== 3'b100) begin errors++; $display("FAIL err_len33_wait: got err/cpu_rst_n/ready=%b expected 100", {load_err, cpu_rst_n, load_ready}); end
    foreach (w[i]) w[i] = 16'($urandom);
    load_prog(2, w, 1'b0, cyc, rc, cs, dn, cn, rn, to);
    checks++; if (to || cyc != 2 || cn !== 1'b1) begin errors++; $display("FAIL post_reset_load: got cycles=%0d cpu_rst_n=%0b timeout=%0b expected 2/1/0", cyc, cn, to); end
    rd(5'd10, d);
    checks++; if (d !== model_mem[10]) begin errors++; $display("FAIL ram_kept_and_wait_write_ignored: got %h expected %h", d, model_mem[10]); end
    rd(5'd1, d);
    checks++; if (d !== w[1]) begin errors++; $display("FAIL post_reset_read1: got %h expected %h", d, w[1]); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_load_basic();
    test_rw_collision();
    test_random();
    test_load_toggle();
    test_reload();
    test_wprot();
    test_load_err();
    test_reset_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_mem_responder.md
Name: ks_mem_responder

Overview:
- Memory-side responder for the K&S processor: a 32 x 16-bit RAM that serves the data path's ram_addr / data_out / data_in interface.
- Also contains a boot loader front-end. An external host streams a program into RAM over a valid/ready handshake while the processor is held in reset, then releases it.
- Sits beside the processor top level, between the testbench/host and the control unit + data path.

Parameters:
- DEPTH, 32, number of 16-bit words; address width is fixed at 5 bits.
- DATA_W, 16, word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ram_addr  input  5  word address from processor.
- ram_wr_en  input  1  processor write strobe.
- ram_wdata  input  16  write data from processor (its data_out).
- ram_rdata  output  16  read data to processor (its data_in).
- load_start  input  1  host request to (re)load a program.
- load_len  input  6  number of words to load; sampled with load_start, valid range 1..32.
- load_valid  input  1  host word valid.
- load_data  input  16  host word.
- load_ready  output  1  responder accepts a word this cycle.
- cpu_rst_n  output  1  synchronous-deassert reset for the processor; 0 = processor held.
- load_done  output  1  one-cycle pulse when the last word is written.
- load_err  output  1  sticky; set on load_start with load_len of 0 or greater than 32.

Behaviour:
- Reset (rst_n=0, async):
  - State goes to WAIT.
  - ram_rdata=0, load_ready=0, cpu_rst_n=0, load_done=0, load_err=0, word pointer=0, length register=0.
  - RAM contents are not cleared by reset.
- FSM states: WAIT, LOAD, RUN.
- WAIT:
  - cpu_rst_n=0, load_ready=0.
  - load_start=1 with load_len in 1..32: latch the length, clear the pointer, go to LOAD.
  - load_start=1 with any other load_len: set load_err, stay in WAIT.
- LOAD:
  - load_ready=1 and cpu_rst_n=0.
  - On load_valid & load_ready: write mem[ptr] <= load_data and increment ptr.
  - When the accepted word is number len (ptr == len-1): the next state is RUN and load_done pulses high for that next cycle.
  - load_start is ignored during LOAD.
  - load_ready drops in the first RUN cycle.
- RUN:
  - cpu_rst_n=1 starting the first cycle after the final word is accepted. Processor PC restarts at 0.
  - Reads: ram_rdata <= mem[ram_addr] every cycle. Registered, 1-cycle latency.
  - Writes: on ram_wr_en=1, mem[ram_addr] <= ram_wdata.
  - Same-cycle read and write to the same address returns OLD data (read-before-write). The new data is visible on the following read.
  - load_start with a valid load_len: go to LOAD and drive cpu_rst_n=0 in the same clock edge. The pointer restarts at 0; words at addresses >= len keep their contents.
  - load_start with an invalid load_len: set load_err, stay in RUN.
- Outside RUN:
  - ram_wr_en is ignored (no RAM write).
  - ram_rdata is held at 0.
- load_err clears only on rst_n.
- Reset asserted mid-LOAD: state returns to WAIT. Partially written words remain in RAM. The host must restart the load.

Optional Feature:
- KS_MEM_WPROT_EN: write protection of the loaded program image.
- Defined:
  - In RUN, a processor write with ram_addr < latched len is suppressed (RAM unchanged).
  - A suppressed write sets the extra output wprot_violation. This port exists only when the macro is defined; it is sticky and cleared by rst_n or by entering LOAD.
  - Reads are unaffected.
- Undefined: all addresses are writable in RUN and the port does not exist.

Test Plan:
- Reset, then load_start with load_len=3 and words 0x8101, 0x8222, 0xFF00 with load_valid held high → load_ready high for 3 cycles; load_done pulses one cycle after the third accept; cpu_rst_n=1 that same cycle; reading addresses 0,1,2 returns 0x8101, 0x8222, 0xFF00 one cycle after each address is applied.
- Load with load_valid toggling every other cycle and load_len=2 → exactly 2 writes occur; no write happens on cycles where load_valid=0.
- In RUN, write 0xABCD to address 20 while reading address 20 in the same cycle → ram_rdata shows the old value; the next cycle shows 0xABCD.
- load_start with load_len=0, then with load_len=33 → load_err=1, state unchanged, cpu_rst_n unchanged; load_err stays set until rst_n.
- In RUN, pulse load_start with load_len=1 → cpu_rst_n=0 after that edge; the new word lands at address 0; address 1 retains its previous value; cpu_rst_n returns to 1 after the accept.
- With KS_MEM_WPROT_EN, load_len=4: a write to address 3 is suppressed and wprot_violation=1; a write to address 4 succeeds. Without the macro, the write to address 3 succeeds.
